// File: rtl/p4_lsu_pkg.sv
// ---------------------------------------------------------------------------
// p4_lsu_pkg
//   Shared types and constants for the P4 load/store unit.
//   - lsu_state_t : bus handshake FSM states
//   - lsu_exc_t   : exception cause encoding driven on o_exc_cause
//   - F3_*        : funct3 access-width codes
//   - ctrl_t      : downstream control bundle carried through P4
//   - p4p5_t      : P4/P5 pipeline register payload
//   - helpers     : width legality, misalignment, bubble payload
// ---------------------------------------------------------------------------
package p4_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    EXC_LD_MISALIGN   = 2'd0,
    EXC_ST_MISALIGN   = 2'd1,
    EXC_BUS_ERR       = 2'd2,
    EXC_ILLEGAL_WIDTH = 2'd3
  } lsu_exc_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic       reg_wr;
    logic [4:0] rd_addr;
    logic [1:0] wb_sel;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] reg_wr_data;
    ctrl_t       ctrl;
    logic [31:0] insn;
  } p4p5_t;

  // Payload the P4/P5 register captures when nothing useful leaves P4.
  function automatic p4p5_t p4p5_bubble();
    p4p5_t b;
    b.reg_wr_data = '0;
    b.ctrl        = '0;
    b.insn        = NOP_INSN;
    return b;
  endfunction

  // Unsigned widths exist only for loads; stores accept B/H/W.
  function automatic logic lsu_width_ok(input logic [2:0] f3, input logic is_load);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return is_load;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return (addr_lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/p4_lsu_align.sv
// ---------------------------------------------------------------------------
// p4_lsu_align
//   Purely combinational lane logic for the load/store unit.
//   Store side: replicates store data across byte lanes and builds the byte
//   enables from the access width and address offset.
//   Load side: picks the addressed byte/halfword out of the bus word and
//   sign- or zero-extends it.
//
//   Ports
//     funct3      in   3  access width / signedness
//     addr_lo     in   2  effective address bits [1:0]
//     is_store    in   1  selects store lane/be generation
//     store_data  in  32  rs2 value
//     rdata       in  32  raw bus read data
//     wdata       out 32  lane-aligned store data
//     be          out  4  byte enables (all ones for loads)
//     load_data   out 32  extracted and extended load value
// ---------------------------------------------------------------------------
module p4_lsu_align
  import p4_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wdata = store_data;
    be    = 4'b1111;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wdata = {4{store_data[7:0]}};
          be    = 4'b0001 << addr_lo;
        end
        F3_H: begin
          wdata = {2{store_data[15:0]}};
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata = store_data;
          be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/p4_lsu.sv
// ---------------------------------------------------------------------------
// p4_lsu
//   P4 memory-access stage. Non-memory instructions pass straight through to
//   the P4/P5 register with no added latency. Loads and stores issue one
//   data-bus request, stall P1-P4 until the response arrives, and then hand
//   the (extended) result to P4/P5. Width and alignment faults are caught
//   before any request and reported as a single-cycle exception pulse.
//
//   Ports
//     i_clk, i_rst_n        clock, async active-low reset
//     i_valid               live instruction in P3/P4
//     i_alu_result          ALU result / effective address
//     i_rs2_data            store data
//     i_funct3              access width and sign
//     i_mem_rd, i_mem_wr    load / store flags (both set = load)
//     i_ctrl, i_insn        passed through to P4/P5
//     o_p4p5                {reg_wr_data, ctrl, insn} to P4/P5
//     o_stall               freeze P1-P4 this cycle
//     o_dbus_*              request: req, we, word address, wdata, be
//     i_dbus_gnt            request accepted
//     i_dbus_rvalid/rdata   response, i_dbus_err qualified by rvalid
//     o_exc, o_exc_cause    exception pulse and cause
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   LSU_IDLE | no transaction; a legal memory op raises req this cycle
//   LSU_REQ  | request outstanding, waiting for grant, bus fields held
//   LSU_WAIT | granted, request dropped, waiting for rvalid
// ---------------------------------------------------------------------------
module p4_lsu
  import p4_lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_data,
  input  logic [2:0]  i_funct3,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  ctrl_t       i_ctrl,
  input  logic [31:0] i_insn,
  output p4p5_t       o_p4p5,
  output logic        o_stall,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [31:0] o_dbus_wdata,
  output logic [3:0]  o_dbus_be,
  input  logic        i_dbus_gnt,
  input  logic        i_dbus_rvalid,
  input  logic [31:0] i_dbus_rdata,
  input  logic        i_dbus_err,
  output logic        o_exc,
  output logic [1:0]  o_exc_cause
);

  lsu_state_t  state_q;
  logic        mem_op;
  logic        is_load;
  logic        is_store;
  logic        width_ok;
  logic        misaligned;
  logic        access_bad;
  lsu_exc_t    bad_cause;
  lsu_exc_t    exc_cause;
  logic [31:0] load_data;

  assign mem_op   = i_valid & (i_mem_rd | i_mem_wr);
  // Both flags set is treated as a load.
  assign is_load  = i_mem_rd;
  assign is_store = i_mem_wr & ~i_mem_rd;

  assign width_ok   = lsu_width_ok(i_funct3, is_load);
  assign misaligned = lsu_misaligned(i_funct3, i_alu_result[1:0]);
  assign access_bad = ~width_ok | misaligned;

  // Illegal width wins over misalignment: alignment is meaningless for an
  // undefined width.
  always_comb begin
    if (!width_ok)    bad_cause = EXC_ILLEGAL_WIDTH;
    else if (is_load) bad_cause = EXC_LD_MISALIGN;
    else              bad_cause = EXC_ST_MISALIGN;
  end

  p4_lsu_align u_align (
    .funct3     (i_funct3),
    .addr_lo    (i_alu_result[1:0]),
    .is_store   (is_store),
    .store_data (i_rs2_data),
    .rdata      (i_dbus_rdata),
    .wdata      (o_dbus_wdata),
    .be         (o_dbus_be),
    .load_data  (load_data)
  );

  // Upstream is frozen while stalled, so these stay stable across REQ.
  assign o_dbus_we   = is_store;
  assign o_dbus_addr = {i_alu_result[31:2], 2'b00};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= LSU_IDLE;
    end else begin
      case (state_q)
        LSU_IDLE: if (mem_op && !access_bad)
                    state_q <= i_dbus_gnt ? LSU_WAIT : LSU_REQ;
        LSU_REQ:  if (i_dbus_gnt)    state_q <= LSU_WAIT;
        LSU_WAIT: if (i_dbus_rvalid) state_q <= LSU_IDLE;
        default:  state_q <= LSU_IDLE;
      endcase
    end
  end

  // Outputs are combinational so a request can go out in the same cycle the
  // instruction arrives. They are also gated by reset so that asserting
  // i_rst_n low drops the request immediately, not at the next edge.
  always_comb begin
    o_dbus_req = 1'b0;
    o_stall    = 1'b0;
    o_exc      = 1'b0;
    exc_cause  = EXC_LD_MISALIGN;
    o_p4p5     = p4p5_bubble();
    if (i_rst_n) begin
      case (state_q)
        LSU_IDLE: begin
          if (i_valid && !mem_op) begin
            o_p4p5.reg_wr_data = i_alu_result;
            o_p4p5.ctrl        = i_ctrl;
            o_p4p5.insn        = i_insn;
          end else if (mem_op && access_bad) begin
            o_exc     = 1'b1;
            exc_cause = bad_cause;
          end else if (mem_op) begin
            o_dbus_req = 1'b1;
            o_stall    = 1'b1;
          end
        end
        LSU_REQ: begin
          o_dbus_req = 1'b1;
          o_stall    = 1'b1;
        end
        LSU_WAIT: begin
          if (!i_dbus_rvalid) begin
            o_stall = 1'b1;
          end else if (i_dbus_err) begin
            o_exc     = 1'b1;
            exc_cause = EXC_BUS_ERR;
          end else begin
            o_p4p5.reg_wr_data = is_store ? i_alu_result : load_data;
            o_p4p5.ctrl        = i_ctrl;
            o_p4p5.insn        = i_insn;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_exc_cause = exc_cause;

endmodule
